// File: rtl/picorv32_freeahb_bridge.sv
// PicoRV32 native memory port to FreeAHB UI bridge: splits writes into aligned
// pieces, places bytes on AHB lanes by endianness, optional per-phase watchdog.
module picorv32_freeahb_bridge #(
    parameter bit          BIG_ENDIAN_AHB = 1'b1,
    parameter bit          MERGE_WSTRB    = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        bus_error,
    output logic [31:0] freeahb_addr,
    output logic [31:0] freeahb_wdata,
    output logic [2:0]  freeahb_size,
    output logic        freeahb_read,
    output logic        freeahb_write,
    output logic        freeahb_valid,
    output logic [31:0] freeahb_min_len,
    output logic        freeahb_cont,
    output logic        freeahb_lock,
    output logic [3:0]  freeahb_prot,
    input  logic        freeahb_next,
    input  logic        freeahb_ready,
    input  logic [31:0] freeahb_rdata,
    input  logic [31:0] freeahb_result_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_DONE
    } state_t;

    typedef struct packed {
        logic [3:0] mask;
        logic [2:0] size;
        logic [1:0] off;
    } piece_t;

    typedef struct packed {
        state_t      state;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        read;
        logic        write;
        logic        valid;
        logic [3:0]  prot;
        logic [31:0] rdata;
        logic        ready;
        logic        err;
        logic [31:0] data;
        logic [3:0]  cur;
        logic [3:0]  rem;
        logic [31:0] cnt;
    } regs_t;

    regs_t  r_q;
    regs_t  w_d;
    piece_t w_piece;
    state_t w_finish;
    logic   w_timeout;
    logic   w_unused;

    // Lowest remaining strobe first, so pieces go out in ascending address order.
    function automatic piece_t next_piece(input logic [3:0] rem);
        piece_t p;
        p = '{4'b0000, 3'd0, 2'd0};
        if (MERGE_WSTRB && rem == 4'b1111)      p = '{4'b1111, 3'd2, 2'd0};
        else if (MERGE_WSTRB && rem[1:0] == 2'b11) p = '{4'b0011, 3'd1, 2'd0};
        else if (rem[0])                        p = '{4'b0001, 3'd0, 2'd0};
        else if (rem[1])                        p = '{4'b0010, 3'd0, 2'd1};
        else if (MERGE_WSTRB && rem[3:2] == 2'b11) p = '{4'b1100, 3'd1, 2'd2};
        else if (rem[2])                        p = '{4'b0100, 3'd0, 2'd2};
        else if (rem[3])                        p = '{4'b1000, 3'd0, 2'd3};
        return p;
    endfunction

    // Moves CPU byte k to its AHB lane; with a full mask this is also the read swap.
    function automatic logic [31:0] place(input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                if (BIG_ENDIAN_AHB) r[8*(3-k) +: 8] = d[8*k +: 8];
                else                r[8*k +: 8]     = d[8*k +: 8];
            end
        end
        return r;
    endfunction

    assign w_finish  = mem_valid ? S_DONE : S_IDLE;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_q.cnt == TIMEOUT_CYCLES - 1);
    assign w_unused  = ^{freeahb_result_addr, mem_addr[1:0]};

    // NOTE: every field starts from its held value, so no path leaves a latch.
    always_comb begin
        w_d       = r_q;
        w_d.ready = 1'b0;
        w_d.err   = 1'b0;
        w_piece   = next_piece(r_q.rem);

        case (r_q.state)
            S_IDLE: begin
                if (mem_valid) begin
                    w_d.prot = {3'b000, ~mem_instr};
                    w_d.data = mem_wdata;
                    if (mem_wstrb == 4'b0000) begin
                        w_d.addr  = {mem_addr[31:2], 2'b00};
                        w_d.size  = 3'd2;
                        w_d.read  = 1'b1;
                        w_d.state = S_RD_ADDR;
                    end else begin
                        w_piece   = next_piece(mem_wstrb);
                        w_d.cur   = w_piece.mask;
                        w_d.rem   = mem_wstrb & ~w_piece.mask;
                        w_d.addr  = {mem_addr[31:2], w_piece.off};
                        w_d.size  = w_piece.size;
                        w_d.write = 1'b1;
                        w_d.state = S_WR_ADDR;
                    end
                end
            end
            S_RD_ADDR, S_RD_DATA: begin
                if (r_q.state == S_RD_ADDR && freeahb_next) begin
                    w_d.read  = 1'b0;
                    w_d.state = S_RD_DATA;
                end
                if ((r_q.state == S_RD_DATA || freeahb_next) && freeahb_ready) begin
                    w_d.rdata = place(freeahb_rdata, 4'b1111);
                    w_d.ready = mem_valid;
                    w_d.state = w_finish;
                end else if (w_d.state == r_q.state && w_timeout) begin
                    w_d.read  = 1'b0;
                    w_d.rdata = ERR_RDATA;
                    w_d.err   = 1'b1;
                    w_d.ready = mem_valid;
                    w_d.state = w_finish;
                end
            end
            S_WR_ADDR: begin
                if (freeahb_next) begin
                    w_d.write = 1'b0;
                    w_d.wdata = place(r_q.data, r_q.cur);
                    w_d.valid = 1'b1;
                    w_d.state = S_WR_DATA;
                end else if (w_timeout) begin
                    w_d.write = 1'b0;
                    w_d.rem   = 4'b0000;
                    w_d.err   = 1'b1;
                    w_d.ready = mem_valid;
                    w_d.state = w_finish;
                end
            end
            S_WR_DATA: begin
                if (freeahb_next) begin
                    w_d.valid = 1'b0;
                    if (r_q.rem != 4'b0000) begin
                        w_d.cur   = w_piece.mask;
                        w_d.rem   = r_q.rem & ~w_piece.mask;
                        w_d.addr  = {r_q.addr[31:2], w_piece.off};
                        w_d.size  = w_piece.size;
                        w_d.write = 1'b1;
                        w_d.state = S_WR_ADDR;
                    end else begin
                        w_d.ready = mem_valid;
                        w_d.state = w_finish;
                    end
                end else if (w_timeout) begin
                    w_d.valid = 1'b0;
                    w_d.rem   = 4'b0000;
                    w_d.err   = 1'b1;
                    w_d.ready = mem_valid;
                    w_d.state = w_finish;
                end
            end
            S_DONE:  w_d.state = S_IDLE;
            default: w_d.state = S_IDLE;
        endcase

        // Watchdog restarts on every state entry and only runs in bus phases.
        if (w_d.state != r_q.state || r_q.state == S_IDLE || r_q.state == S_DONE)
            w_d.cnt = '0;
        else
            w_d.cnt = r_q.cnt + 32'd1;
    end

    // NOTE: non-blocking updates; async reset clears the whole register bundle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_q <= '0;
        else         r_q <= w_d;
    end

    assign mem_ready       = r_q.ready;
    assign mem_rdata       = r_q.rdata;
    assign bus_error       = r_q.err;
    assign freeahb_addr    = r_q.addr;
    assign freeahb_wdata   = r_q.wdata;
    assign freeahb_size    = r_q.size;
    assign freeahb_read    = r_q.read;
    assign freeahb_write   = r_q.write;
    assign freeahb_valid   = r_q.valid;
    assign freeahb_prot    = r_q.prot;
    assign freeahb_min_len = 32'd0;
    assign freeahb_cont    = 1'b0;
    assign freeahb_lock    = 1'b0;

endmodule

// File: tb/tb_picorv32_freeahb_bridge.sv
// Directed bench: three bridge instances (LE+merge+watchdog, BE+merge, LE no-merge)
// share stimulus; only the selected instance sees mem_valid.
module tb_picorv32_freeahb_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  mem_valid_v;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        ahb_next;
    logic        ahb_ready;
    logic [31:0] ahb_rdata;
    logic [31:0] ahb_result;

    logic        o_ready   [3];
    logic [31:0] o_rdata   [3];
    logic        o_err     [3];
    logic [31:0] o_addr    [3];
    logic [31:0] o_wdata   [3];
    logic [2:0]  o_size    [3];
    logic        o_read    [3];
    logic        o_write   [3];
    logic        o_valid   [3];
    logic [31:0] o_min_len [3];
    logic        o_cont    [3];
    logic        o_lock    [3];
    logic [3:0]  o_prot    [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        picorv32_freeahb_bridge #(
            .BIG_ENDIAN_AHB (g == 1),
            .MERGE_WSTRB    (g != 2),
            .TIMEOUT_CYCLES (g == 0 ? 8 : 0),
            .ERR_RDATA      (32'hDEADBEEF)
        ) u_dut (
            .clk                 (clk),
            .resetn              (resetn),
            .mem_valid           (mem_valid_v[g]),
            .mem_instr           (mem_instr),
            .mem_addr            (mem_addr),
            .mem_wdata           (mem_wdata),
            .mem_wstrb           (mem_wstrb),
            .mem_ready           (o_ready[g]),
            .mem_rdata           (o_rdata[g]),
            .bus_error           (o_err[g]),
            .freeahb_addr        (o_addr[g]),
            .freeahb_wdata       (o_wdata[g]),
            .freeahb_size        (o_size[g]),
            .freeahb_read        (o_read[g]),
            .freeahb_write       (o_write[g]),
            .freeahb_valid       (o_valid[g]),
            .freeahb_min_len     (o_min_len[g]),
            .freeahb_cont        (o_cont[g]),
            .freeahb_lock        (o_lock[g]),
            .freeahb_prot        (o_prot[g]),
            .freeahb_next        (ahb_next),
            .freeahb_ready       (ahb_ready),
            .freeahb_rdata       (ahb_rdata),
            .freeahb_result_addr (ahb_result)
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int idx, input string tag);
        check({tag, "_ctl"}, 32'({o_ready[idx], o_err[idx], o_read[idx], o_write[idx],
                                  o_valid[idx], o_cont[idx], o_lock[idx]}), 32'd0);
        check({tag, "_addr"},  o_addr[idx],  32'd0);
        check({tag, "_wdata"}, o_wdata[idx], 32'd0);
        check({tag, "_rdata"}, o_rdata[idx], 32'd0);
        check({tag, "_size_prot"}, 32'({o_size[idx], o_prot[idx]}), 32'd0);
        check({tag, "_min_len"}, o_min_len[idx], 32'd0);
    endtask

    // Called at a negedge; returns one negedge after the request edge.
    task automatic start_req(input int idx, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic instr);
        mem_addr    = addr;
        mem_wdata   = wdata;
        mem_wstrb   = strb;
        mem_instr   = instr;
        mem_valid_v = 3'b001 << idx;
        @(negedge clk);
    endtask

    task automatic end_req(input int idx, input string tag);
        mem_valid_v = 3'b000;
        @(negedge clk);
        check({tag, "_ready_drop"}, 32'({o_ready[idx], o_err[idx]}), 32'd0);
        @(negedge clk);
    endtask

    task automatic do_read(input int idx, input string tag, input logic [31:0] addr,
                           input logic instr, input logic [31:0] bus_data,
                           input logic [31:0] exp_addr, input logic [31:0] exp_rdata,
                           input logic [3:0] exp_prot);
        start_req(idx, addr, 32'd0, 4'b0000, instr);
        check({tag, "_issue"}, 32'({o_read[idx], o_write[idx], o_valid[idx]}), 32'b100);
        check({tag, "_addr"}, o_addr[idx], exp_addr);
        check({tag, "_size"}, 32'(o_size[idx]), 32'd2);
        check({tag, "_prot"}, 32'(o_prot[idx]), 32'(exp_prot));
        ahb_next = 1'b1;
        @(negedge clk);
        ahb_next = 1'b0;
        check({tag, "_rd_drop"}, 32'({o_read[idx], o_ready[idx]}), 32'd0);
        ahb_ready = 1'b1;
        ahb_rdata = bus_data;
        @(negedge clk);
        ahb_ready = 1'b0;
        ahb_rdata = 32'd0;
        check({tag, "_ready"}, 32'(o_ready[idx]), 32'd1);
        check({tag, "_rdata"}, o_rdata[idx], exp_rdata);
        check({tag, "_const"}, o_min_len[idx] | 32'({o_cont[idx], o_lock[idx]}), 32'd0);
        end_req(idx, tag);
    endtask

    // One address phase plus one data phase, both accepted at the first opportunity.
    task automatic do_piece(input int idx, input string tag, input logic [31:0] exp_addr,
                            input logic [2:0] exp_size, input logic [31:0] exp_wdata,
                            input logic last);
        check({tag, "_issue"}, 32'({o_read[idx], o_write[idx], o_valid[idx]}), 32'b010);
        check({tag, "_addr"}, o_addr[idx], exp_addr);
        check({tag, "_size"}, 32'(o_size[idx]), 32'(exp_size));
        ahb_next = 1'b1;
        @(negedge clk);
        check({tag, "_data"}, 32'({o_read[idx], o_write[idx], o_valid[idx]}), 32'b001);
        check({tag, "_wdata"}, o_wdata[idx], exp_wdata);
        @(negedge clk);
        ahb_next = 1'b0;
        check({tag, "_ready"}, 32'(o_ready[idx]), 32'(last));
    endtask

    initial begin
        resetn      = 1'b0;
        mem_valid_v = 3'b000;
        mem_instr   = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        mem_wstrb   = 4'b0000;
        ahb_next    = 1'b0;
        ahb_ready   = 1'b0;
        ahb_rdata   = 32'd0;
        ahb_result  = 32'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset(i, "reset");
        resetn = 1'b1;
        @(negedge clk);

        do_read(0, "rd_le",    32'h0000_0100, 1'b0, 32'h1122_3344, 32'h0000_0100, 32'h1122_3344, 4'b0001);
        do_read(1, "rd_be",    32'h0000_0100, 1'b0, 32'h1122_3344, 32'h0000_0100, 32'h4433_2211, 4'b0001);
        do_read(2, "rd_instr", 32'h0000_0107, 1'b1, 32'hCAFE_F00D, 32'h0000_0104, 32'hCAFE_F00D, 4'b0000);

        start_req(1, 32'h0000_0300, 32'hAABB_CCDD, 4'b1111, 1'b0);
        do_piece(1, "wr_be_word", 32'h0000_0300, 3'd2, 32'hDDCC_BBAA, 1'b1);
        end_req(1, "wr_be_word");

        start_req(0, 32'h0000_0200, 32'hAABB_CCDD, 4'b1110, 1'b0);
        do_piece(0, "wr1110_b1", 32'h0000_0201, 3'd0, 32'h0000_CC00, 1'b0);
        do_piece(0, "wr1110_h2", 32'h0000_0202, 3'd1, 32'hAABB_0000, 1'b1);
        end_req(0, "wr1110");

        start_req(2, 32'h0000_0200, 32'hAABB_CCDD, 4'b1110, 1'b0);
        do_piece(2, "nm1110_b1", 32'h0000_0201, 3'd0, 32'h0000_CC00, 1'b0);
        do_piece(2, "nm1110_b2", 32'h0000_0202, 3'd0, 32'h00BB_0000, 1'b0);
        do_piece(2, "nm1110_b3", 32'h0000_0203, 3'd0, 32'hAA00_0000, 1'b1);
        end_req(2, "nm1110");

        start_req(0, 32'h0000_0200, 32'hAABB_CCDD, 4'b0110, 1'b0);
        do_piece(0, "wr0110_b1", 32'h0000_0201, 3'd0, 32'h0000_CC00, 1'b0);
        do_piece(0, "wr0110_b2", 32'h0000_0202, 3'd0, 32'h00BB_0000, 1'b1);
        end_req(0, "wr0110");

        start_req(0, 32'h0000_0208, 32'h1122_3344, 4'b1011, 1'b0);
        do_piece(0, "wr1011_h0", 32'h0000_0208, 3'd1, 32'h0000_3344, 1'b0);
        do_piece(0, "wr1011_b3", 32'h0000_020B, 3'd0, 32'h1100_0000, 1'b1);
        end_req(0, "wr1011");

        start_req(1, 32'h0000_020C, 32'hAABB_CCDD, 4'b0011, 1'b0);
        do_piece(1, "wr_be_h0", 32'h0000_020C, 3'd1, 32'hDDCC_0000, 1'b1);
        end_req(1, "wr_be_h0");

        // Read with next never asserted: abort on the 8th cycle in RD_ADDR.
        start_req(0, 32'h0000_0400, 32'd0, 4'b0000, 1'b0);
        check("to_issue", 32'(o_read[0]), 32'd1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("to_wait", 32'({o_err[0], o_ready[0], o_read[0]}), 32'b001);
        end
        @(negedge clk);
        check("to_fire", 32'({o_err[0], o_ready[0], o_read[0]}), 32'b110);
        check("to_rdata", o_rdata[0], 32'hDEAD_BEEF);
        end_req(0, "to");

        // Reset asserted during the data phase of the first of two pieces.
        start_req(0, 32'h0000_0210, 32'hAABB_CCDD, 4'b0110, 1'b0);
        check("rst_issue", 32'(o_write[0]), 32'd1);
        ahb_next = 1'b1;
        @(negedge clk);
        check("rst_in_wdata", 32'(o_valid[0]), 32'd1);
        resetn = 1'b0;
        #1;
        check_reset(0, "rst_mid");
        ahb_next    = 1'b0;
        mem_valid_v = 3'b000;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        do_read(0, "rd_after_rst", 32'h0000_0220, 1'b0, 32'h5566_7788, 32'h0000_0220, 32'h5566_7788, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
